// File: rtl/tmr_vote_monitor.sv
// TMR receive-side voter: registered bitwise majority, per-replica saturating
// disagreement counters and a one-shot fault report over valid/ready.

module tmr_vote_cnt #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_mis,
    input  logic             i_take,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_pend
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_rep;
    logic [CNT_W-1:0] w_nxt;
    logic             w_hit;

    assign w_nxt = (i_mis && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;
    // A replica is flagged only once; r_rep stays set until clr or reset.
    assign w_hit = (w_nxt >= THR) && !r_rep;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_rep  <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_rep  <= 1'b0;
        end else begin
            r_cnt <= w_nxt;
            if (w_hit) begin
                r_pend <= 1'b1;
                r_rep  <= 1'b1;
            end else if (i_take) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_pend = r_pend;
endmodule

module tmr_vote_monitor #(
    parameter int WIDTH  = 2,
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_rep_a,
    input  logic [WIDTH-1:0] i_rep_b,
    input  logic [WIDTH-1:0] i_rep_c,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_voted,
    output logic             o_voted_valid,
    output logic             o_multi_fault,
    output logic [CNT_W-1:0] o_err_cnt_a,
    output logic [CNT_W-1:0] o_err_cnt_b,
    output logic [CNT_W-1:0] o_err_cnt_c,
    output logic             o_rpt_valid,
    input  logic             i_rpt_ready,
    output logic [1:0]       o_rpt_replica,
    output logic [CNT_W-1:0] o_rpt_count
);
    typedef enum logic {IDLE, SEND} state_t;

    logic [2:0][WIDTH-1:0] w_rep;
    logic [WIDTH-1:0]      w_maj;
    logic [2:0]            w_mis;
    logic [2:0]            w_cnt_en;
    logic                  w_multi;
    logic [2:0][CNT_W-1:0] w_cnt;
    logic [2:0]            w_pend;
    logic [2:0]            w_take;
    logic [1:0]            w_sel;
    logic [CNT_W-1:0]      w_sel_cnt;

    state_t           r_state;
    logic [WIDTH-1:0] r_voted;
    logic             r_voted_valid;
    logic             r_multi_fault;
    logic             r_rpt_valid;
    logic [1:0]       r_rpt_replica;
    logic [CNT_W-1:0] r_rpt_count;

    assign w_rep = {i_rep_c, i_rep_b, i_rep_a};
    assign w_maj = (i_rep_a & i_rep_b) | (i_rep_a & i_rep_c) | (i_rep_b & i_rep_c);

    // multi_fault belongs to the vote path, so clr masks only the counting.
    assign w_multi  = (w_mis[0] & w_mis[1]) | (w_mis[0] & w_mis[2]) | (w_mis[1] & w_mis[2]);
    assign w_cnt_en = w_mis & {3{~i_clr}};

    for (genvar g = 0; g < 3; g++) begin : g_rep
        assign w_mis[g] = i_in_valid & (w_rep[g] != w_maj);

        tmr_vote_cnt #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (i_clr),
            .i_mis   (w_cnt_en[g]),
            .i_take  (w_take[g]),
            .o_cnt   (w_cnt[g]),
            .o_pend  (w_pend[g])
        );
    end

    always_comb begin
        w_sel     = 2'd0;
        w_sel_cnt = w_cnt[0];
        if (w_pend[0]) begin
            w_sel     = 2'd0;
            w_sel_cnt = w_cnt[0];
        end else if (w_pend[1]) begin
            w_sel     = 2'd1;
            w_sel_cnt = w_cnt[1];
        end else if (w_pend[2]) begin
            w_sel     = 2'd2;
            w_sel_cnt = w_cnt[2];
        end
    end

    assign w_take = (r_state == IDLE && !i_clr && (|w_pend)) ? (3'b001 << w_sel) : 3'b000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_voted       <= '0;
            r_voted_valid <= 1'b0;
            r_multi_fault <= 1'b0;
        end else begin
            if (i_in_valid) r_voted <= w_maj;
            r_voted_valid <= i_in_valid;
            r_multi_fault <= w_multi;
        end
    end

    // Report FSM; the IDLE pass between reports gives the mandatory gap cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_rpt_valid   <= 1'b0;
            r_rpt_replica <= 2'd0;
            r_rpt_count   <= '0;
        end else if (i_clr) begin
            r_state     <= IDLE;
            r_rpt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_pend) begin
                        r_rpt_replica <= w_sel;
                        r_rpt_count   <= w_sel_cnt;
                        r_rpt_valid   <= 1'b1;
                        r_state       <= SEND;
                    end
                end
                SEND: begin
                    if (i_rpt_ready) begin
                        r_rpt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_voted       = r_voted;
    assign o_voted_valid = r_voted_valid;
    assign o_multi_fault = r_multi_fault;
    assign o_err_cnt_a   = w_cnt[0];
    assign o_err_cnt_b   = w_cnt[1];
    assign o_err_cnt_c   = w_cnt[2];
    assign o_rpt_valid   = r_rpt_valid;
    assign o_rpt_replica = r_rpt_replica;
    assign o_rpt_count   = r_rpt_count;
endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: two instances (CNT_W=8 and CNT_W=2) share stimulus
// and are checked every cycle against a behavioural model, plus literal pins.

module tb_tmr_vote_monitor;
    localparam int THRESH = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] rep_a = '0, rep_b = '0, rep_c = '0;
    logic       clr = 1'b0;
    logic       rpt_ready = 1'b0;

    logic [1:0] v0, v1;
    logic       vv0, vv1, mf0, mf1, rv0, rv1;
    logic [7:0] ca0, cb0, cc0, rc0;
    logic [1:0] ca1, cb1, cc1, rc1;
    logic [1:0] rr0, rr1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tmr_vote_monitor #(.WIDTH(2), .CNT_W(8), .THRESH(THRESH)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid),
        .i_rep_a(rep_a), .i_rep_b(rep_b), .i_rep_c(rep_c), .i_clr(clr),
        .o_voted(v0), .o_voted_valid(vv0), .o_multi_fault(mf0),
        .o_err_cnt_a(ca0), .o_err_cnt_b(cb0), .o_err_cnt_c(cc0),
        .o_rpt_valid(rv0), .i_rpt_ready(rpt_ready),
        .o_rpt_replica(rr0), .o_rpt_count(rc0)
    );

    tmr_vote_monitor #(.WIDTH(2), .CNT_W(2), .THRESH(THRESH)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid),
        .i_rep_a(rep_a), .i_rep_b(rep_b), .i_rep_c(rep_c), .i_clr(clr),
        .o_voted(v1), .o_voted_valid(vv1), .o_multi_fault(mf1),
        .o_err_cnt_a(ca1), .o_err_cnt_b(cb1), .o_err_cnt_c(cc1),
        .o_rpt_valid(rv1), .i_rpt_ready(rpt_ready),
        .o_rpt_replica(rr1), .o_rpt_count(rc1)
    );

    // Behavioural model; index d selects the instance (0: CNT_W=8, 1: CNT_W=2).
    int m_voted, m_vv, m_mf;
    int m_cnt  [2][3];
    bit m_pend [2][3];
    bit m_done [2][3];
    bit m_busy [2];
    int m_rr   [2];
    int m_rc   [2];
    int m_max  [2] = '{255, 3};

    task automatic model_reset();
        m_voted = 0; m_vv = 0; m_mf = 0;
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_rr[d] = 0; m_rc[d] = 0;
            for (int k = 0; k < 3; k++) begin
                m_cnt[d][k] = 0; m_pend[d][k] = 0; m_done[d][k] = 0;
            end
        end
    endtask

    task automatic model_step();
        int r [3];
        int maj, nmis;
        bit served;
        r[0] = rep_a; r[1] = rep_b; r[2] = rep_c;
        maj = 0;
        for (int b = 0; b < 2; b++)
            if (r[0][b] + r[1][b] + r[2][b] >= 2) maj += (1 << b);
        nmis = 0;
        for (int k = 0; k < 3; k++) if (r[k] != maj) nmis++;
        if (in_valid) begin
            m_voted = maj; m_vv = 1; m_mf = (nmis >= 2);
        end else begin
            m_vv = 0; m_mf = 0;
        end
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                m_busy[d] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_cnt[d][k] = 0; m_pend[d][k] = 0; m_done[d][k] = 0;
                end
            end else begin
                if (!m_busy[d]) begin
                    served = 0;
                    for (int k = 0; k < 3; k++) begin
                        if (!served && m_pend[d][k]) begin
                            served = 1; m_busy[d] = 1; m_rr[d] = k;
                            m_rc[d] = m_cnt[d][k]; m_pend[d][k] = 0;
                        end
                    end
                end else if (rpt_ready) begin
                    m_busy[d] = 0;
                end
                for (int k = 0; k < 3; k++) begin
                    if (in_valid && r[k] != maj && m_cnt[d][k] < m_max[d]) m_cnt[d][k]++;
                    if (m_cnt[d][k] >= THRESH && !m_done[d][k]) begin
                        m_pend[d][k] = 1; m_done[d][k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("voted0", v0, m_voted);        chk("voted1", v1, m_voted);
        chk("voted_valid0", vv0, m_vv);    chk("voted_valid1", vv1, m_vv);
        chk("multi_fault0", mf0, m_mf);    chk("multi_fault1", mf1, m_mf);
        chk("err_a0", ca0, m_cnt[0][0]);   chk("err_b0", cb0, m_cnt[0][1]);
        chk("err_c0", cc0, m_cnt[0][2]);   chk("err_a1", ca1, m_cnt[1][0]);
        chk("err_b1", cb1, m_cnt[1][1]);   chk("err_c1", cc1, m_cnt[1][2]);
        chk("rpt_valid0", rv0, m_busy[0]); chk("rpt_valid1", rv1, m_busy[1]);
        if (m_busy[0]) begin
            chk("rpt_replica0", rr0, m_rr[0]); chk("rpt_count0", rc0, m_rc[0]);
        end
        if (m_busy[1]) begin
            chk("rpt_replica1", rr1, m_rr[1]); chk("rpt_count1", rc1, m_rc[1]);
        end
    endtask

    task automatic step(input int a, input int b, input int c, input bit v,
                        input bit cl, input bit rdy);
        @(negedge clk);
        rep_a = 2'(a); rep_b = 2'(b); rep_c = 2'(c);
        in_valid = v; clr = cl; rpt_ready = rdy;
        @(posedge clk);
        model_step();
        #1 compare_all();
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();
        chk("lit_reset_rpt_valid", rv0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean vote
        step(2, 2, 2, 1, 0, 0);
        chk("lit_voted_clean", v0, 2);
        chk("lit_vv_clean", vv0, 1);

        // Single-replica fault on A, report one cycle after the third mismatch
        repeat (3) step(1, 2, 2, 1, 0, 0);
        chk("lit_err_a_3", ca0, 3);
        chk("lit_err_b_0", cb0, 0);
        step(2, 2, 2, 1, 0, 0);
        chk("lit_rpt_valid", rv0, 1);
        chk("lit_rpt_replica_a", rr0, 0);
        chk("lit_rpt_count_3", rc0, 3);

        // Backpressure, accept, then no second report
        repeat (5) step(2, 2, 2, 1, 0, 0);
        chk("lit_rpt_held", rc0, 3);
        step(2, 2, 2, 1, 0, 1);
        chk("lit_rpt_accepted", rv0, 0);
        repeat (3) step(1, 2, 2, 1, 0, 1);
        chk("lit_err_a_6", ca0, 6);
        chk("lit_err_a_sat", ca1, 3);
        chk("lit_no_second_rpt", rv0, 0);

        // Per-bit vote with two faulty replicas
        step(0, 3, 1, 1, 0, 1);
        chk("lit_voted_perbit", v0, 1);
        chk("lit_multi_fault", mf0, 1);

        // Simultaneous B/C crossing, priority B then C with a gap cycle
        step(2, 2, 2, 1, 1, 0);
        repeat (3) step(0, 1, 2, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("lit_rpt_b_first", rr1, 1);
        chk("lit_rpt_b_valid", rv1, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("lit_gap_cycle", rv1, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("lit_rpt_c_second", rr1, 2);
        chk("lit_rpt_c_valid", rv1, 1);
        step(0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 1, 0, 1, 0, 1);
        chk("lit_err_b_sat", cb1, 3);
        chk("lit_err_b_wide", cb0, 5);

        // Clear mid-report, then a fresh report after THRESH more mismatches
        step(2, 2, 2, 1, 1, 0);
        repeat (3) step(1, 2, 2, 1, 0, 0);
        step(2, 2, 2, 1, 0, 0);
        chk("lit_rpt_before_clr", rv0, 1);
        step(2, 2, 2, 1, 1, 0);
        chk("lit_clr_aborts", rv0, 0);
        chk("lit_clr_cnt", ca0, 0);
        chk("lit_clr_vote_kept", vv0, 1);
        repeat (3) step(1, 2, 2, 1, 0, 0);
        step(2, 2, 2, 1, 0, 0);
        chk("lit_fresh_rpt", rv0, 1);
        chk("lit_fresh_count", rc0, 3);

        // Asynchronous reset while a report is outstanding
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("lit_async_rst_rpt", rv0, 0);
        chk("lit_async_rst_cnt", ca0, 0);
        model_reset();
        compare_all();
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int base, a, b, c, sel;
            base = int'($urandom_range(0, 3));
            a = base; b = base; c = base;
            sel = int'($urandom_range(0, 15));
            if (sel < 4) begin
                case ($urandom_range(0, 2))
                    0: a = int'($urandom_range(0, 3));
                    1: b = int'($urandom_range(0, 3));
                    default: c = int'($urandom_range(0, 3));
                endcase
            end else if (sel == 4) begin
                a = int'($urandom_range(0, 3));
                b = int'($urandom_range(0, 3));
                c = int'($urandom_range(0, 3));
            end
            step(a, b, c, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Receiving end of a triplicated register cone: accepts three replicas of a WIDTH-bit pipeline output each cycle.
- Produces a registered bitwise-majority result.
- Tracks per-replica disagreement in saturating counters.
- When a replica's error count reaches a threshold, emits one fault report over a valid/ready handshake to a scrub/diagnostic controller.

Parameters:
- WIDTH, 2, data width of each replica and of the voted output
- CNT_W, 8, width of each per-replica error counter
- THRESH, 3, error count at which a replica is reported faulty; legal range 1..2^CNT_W-1

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  replicas valid this cycle
- rep_a  input  WIDTH  replica A
- rep_b  input  WIDTH  replica B
- rep_c  input  WIDTH  replica C
- clr  input  1  synchronous clear of counters, flags and report state
- voted  output  WIDTH  registered bitwise majority
- voted_valid  output  1  voted holds a new result
- multi_fault  output  1  registered; two or more replicas disagreed with the majority in the same accepted cycle
- err_cnt_a  output  CNT_W  error count, replica A
- err_cnt_b  output  CNT_W  error count, replica B
- err_cnt_c  output  CNT_W  error count, replica C
- rpt_valid  output  1  fault report available
- rpt_ready  input  1  consumer accepts report
- rpt_replica  output  2  reported replica: 0=A, 1=B, 2=C
- rpt_count  output  CNT_W  replica's counter value when its report was launched

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; counters, pending flags and reported flags 0; FSM in IDLE.
- Majority (combinational): maj = (a&b)|(a&c)|(b&c), bitwise.
- Vote path:
  - When in_valid: voted <= maj and voted_valid <= 1 on the next edge (latency 1).
  - When in_valid is low: voted holds its value and voted_valid <= 0.
- Mismatch:
  - mis_x = in_valid & (rep_x != maj), per replica.
  - multi_fault <= in_valid & (popcount(mis) >= 2), with the same latency as voted. It is 0 when in_valid is low.
- Counters:
  - Each increments by 1 when its mis_x is set.
  - Saturates at 2^CNT_W-1 with no wrap.
- Threshold:
  - When a counter's next value is >= THRESH and its reported flag is clear, set its pending flag and its reported flag.
  - Each replica is reported at most once until clr.
- Report FSM, states IDLE and SEND:
  - IDLE: if any pending flag is set, select by fixed priority A>B>C. Load rpt_replica and rpt_count (the counter value at load), clear that pending flag, set rpt_valid, then go to SEND.
  - SEND: rpt_valid, rpt_replica and rpt_count are held stable until rpt_valid & rpt_ready at a rising edge. On that edge rpt_valid <= 0 and the FSM returns to IDLE.
  - Consecutive reports are separated by at least one idle cycle.
  - Pending flags raised while in SEND are kept and served later in priority order.
- clr (synchronous, highest priority):
  - Zeroes counters, pending flags and reported flags.
  - FSM goes to IDLE; rpt_valid <= 0, which aborts any in-flight report.
  - The vote path is unaffected: an in_valid on the same cycle still produces voted, but mismatches on that cycle are not counted.
- Simultaneous threshold crossings: all affected replicas get pending flags in the same cycle; reports are then issued sequentially A, B, C.
- Reset mid-report: rpt_valid drops immediately, asynchronously.

Test Plan:
- Reset with WIDTH=2, THRESH=3: all outputs 0. Drive a=b=c=2'b10 with in_valid -> next cycle voted=2'b10, voted_valid=1, all counters 0, multi_fault=0.
- Single-replica fault: a=2'b01, b=c=2'b10 for 3 valid cycles -> voted=2'b10 each cycle; err_cnt_a=1,2,3; err_cnt_b and err_cnt_c stay 0. One cycle after the third mismatch, rpt_valid=1, rpt_replica=0, rpt_count=3.
- Backpressure and once-only report: hold rpt_ready=0 for 5 cycles -> rpt fields stable. Then rpt_ready=1 for 1 cycle -> rpt_valid=0 next cycle. Continued A faults -> counter keeps rising, no second report.
- Per-bit vote with two faulty replicas: a=2'b00, b=2'b11, c=2'b01 -> voted=2'b01; mis_a=1, mis_b=1, mis_c=0; multi_fault=1 next cycle.
- Priority and saturation, CNT_W=2, THRESH=3:
  - b and c reach 3 on the same cycle -> report C (2) issues after report B (1) is accepted, with one idle cycle between.
  - Further b faults -> err_cnt_b stays 3.
- Clear mid-report: clr asserted while rpt_valid=1 -> next cycle rpt_valid=0 and counters 0. The same faults then produce a fresh report after THRESH more mismatches.
